// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. It registers the instruction leaving MEM and picks
// the writeback source: ALU result, load data or link address. Sub-word load
// data is aligned and extended here. When load data is late, the stage holds
// the load in WAIT until mem_rvalid arrives.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic [1:0]        ex_mem_to_reg,
    input  logic [1:0]        ex_load_size,
    input  logic              ex_load_unsigned,
    input  logic [1:0]        ex_addr_low,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_pc_plus4,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic              stall_out,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_write_reg,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              wb_misalign
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_LINK = 2'b10;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;

    state_t              state_q, state_d;
    logic                stall_q, stall_d;
    // Load control fields held while the read data is outstanding
    logic                rw_q, rw_d;
    logic [REG_AW-1:0]   wreg_q, wreg_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          addr_q, addr_d;
    // Writeback outputs
    logic                vld_q, vld_d;
    logic                wbrw_q, wbrw_d;
    logic [REG_AW-1:0]   wbreg_q, wbreg_d;
    logic [DATA_W-1:0]   wbdata_q, wbdata_d;
    logic                mis_q, mis_d;

    // Instruction fields come from the latched copy in WAIT, else from ex_*
    logic                in_wait, sel_rw, sel_uns, is_load, misalign, commit;
    logic [REG_AW-1:0]   sel_reg;
    logic [1:0]          sel_src, sel_size, sel_addr;
    logic [15:0]         half;
    logic [7:0]          byte_v;
    logic [DATA_W-1:0]   load_data, result;

    // Source select, load alignment/extension and misalignment detect
    always_comb begin
        in_wait  = (state_q == S_WAIT);
        sel_rw   = in_wait ? rw_q   : ex_reg_write;
        sel_reg  = in_wait ? wreg_q : ex_write_reg;
        sel_src  = in_wait ? SRC_LOAD : ex_mem_to_reg;
        sel_size = in_wait ? size_q : ex_load_size;
        sel_uns  = in_wait ? uns_q  : ex_load_unsigned;
        sel_addr = in_wait ? addr_q : ex_addr_low;
        is_load  = (sel_src == SRC_LOAD);

        half     = sel_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_v   = mem_rdata[{sel_addr, 3'b000} +: 8];
        case (sel_size)
            SZ_HALF: load_data = {{16{~sel_uns & half[15]}}, half};
            SZ_BYTE: load_data = {{24{~sel_uns & byte_v[7]}}, byte_v};
            default: load_data = mem_rdata;
        endcase

        misalign = 1'b0;
        if (is_load) begin
            if (sel_size == SZ_HALF)
                misalign = sel_addr[0];
            else if (sel_size != SZ_BYTE)
                misalign = (sel_addr != 2'b00);
        end

        case (sel_src)
            SRC_LOAD: result = load_data;
            SRC_LINK: result = ex_pc_plus4;
            default:  result = ex_alu_result;
        endcase
    end

    // Next state: capture, wait for read data, or flush to a bubble
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        wreg_d   = wreg_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        commit   = 1'b0;
        vld_d    = 1'b0;
        wbrw_d   = 1'b0;
        mis_d    = 1'b0;
        wbreg_d  = wbreg_q;
        wbdata_d = wbdata_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (is_load && !mem_rvalid) begin
                            state_d = S_WAIT;
                            rw_d    = ex_reg_write;
                            wreg_d  = ex_write_reg;
                            size_d  = ex_load_size;
                            uns_d   = ex_load_unsigned;
                            addr_d  = ex_addr_low;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
                default: begin
                    if (mem_rvalid) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end

        if (commit) begin
            vld_d    = 1'b1;
            wbreg_d  = sel_reg;
            wbdata_d = result;
            mis_d    = misalign;
            wbrw_d   = sel_rw & (sel_reg != '0) & ~misalign;
        end

        stall_d = (state_d == S_WAIT);
    end

    // State, latched load fields and writeback registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            stall_q  <= 1'b0;
            rw_q     <= 1'b0;
            wreg_q   <= '0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= 2'b00;
            vld_q    <= 1'b0;
            wbrw_q   <= 1'b0;
            wbreg_q  <= '0;
            wbdata_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            rw_q     <= rw_d;
            wreg_q   <= wreg_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            vld_q    <= vld_d;
            wbrw_q   <= wbrw_d;
            wbreg_q  <= wbreg_d;
            wbdata_q <= wbdata_d;
            mis_q    <= mis_d;
        end
    end

    assign stall_out     = stall_q;
    assign wb_valid      = vld_q;
    assign wb_reg_write  = wbrw_q;
    assign wb_write_reg  = wbreg_q;
    assign wb_write_data = wbdata_q;
    assign wb_misalign   = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage. The stimulus pushes the expected
// writebacks into a queue, and the monitor pops one each time wb_valid is seen.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_reg_write, ex_load_unsigned, mem_rvalid, flush;
    logic [4:0]  ex_write_reg;
    logic [1:0]  ex_mem_to_reg, ex_load_size, ex_addr_low;
    logic [31:0] ex_alu_result, ex_pc_plus4, mem_rdata;
    logic        stall_out, wb_valid, wb_reg_write, wb_misalign;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] data;
        logic        mis;
        logic        cd;   // compare data (not defined for misaligned loads)
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_load_size(ex_load_size),
        .ex_load_unsigned(ex_load_unsigned), .ex_addr_low(ex_addr_low),
        .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
        .stall_out(stall_out), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .wb_misalign(wb_misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [4:0] wr, input logic [31:0] d,
                        input logic mis, input logic cd);
        exp_t e;
        e.rw = rw; e.wr = wr; e.data = d; e.mis = mis; e.cd = cd;
        sb.push_back(e);
    endtask

    task automatic idle();
        ex_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic alu(input logic [4:0] wr, input logic [1:0] src, input logic [31:0] v);
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_write_reg = wr; ex_mem_to_reg = src;
        ex_alu_result = v; ex_pc_plus4 = v; mem_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic load(input logic [4:0] wr, input logic [1:0] sz, input logic uns,
                        input logic [1:0] al, input logic [31:0] rd, input logic rv);
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_write_reg = wr; ex_mem_to_reg = 2'b01;
        ex_load_size = sz; ex_load_unsigned = uns; ex_addr_low = al;
        ex_alu_result = 32'h1111_1111; ex_pc_plus4 = 32'h2222_2222;
        mem_rdata = rd; mem_rvalid = rv; flush = 1'b0;
    endtask

    // Monitor: every valid writeback must match the oldest expectation
    always @(negedge clk) begin
        if (reset && wb_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_wb: got reg %0d data %h expected no writeback",
                         wb_write_reg, wb_write_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, e.wr});
                chk("wb_misalign", {31'd0, wb_misalign}, {31'd0, e.mis});
                if (e.cd) chk("wb_write_data", wb_write_data, e.data);
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle();
        ex_reg_write = 1'b0; ex_write_reg = '0; ex_mem_to_reg = '0; ex_load_size = '0;
        ex_load_unsigned = 1'b0; ex_addr_low = '0; ex_alu_result = '0; ex_pc_plus4 = '0;
        mem_rdata = '0;

        @(negedge clk);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_mis", {31'd0, wb_misalign}, 32'd0);
        chk("rst_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("rst_data", wb_write_data, 32'd0);
        reset = 1'b1;

        // ALU op, then a bubble that must hold reg/data
        alu(5'd8, 2'b00, 32'h1234_5678); push(1'b1, 5'd8, 32'h1234_5678, 1'b0, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);
        chk("bubble_valid", {31'd0, wb_valid}, 32'd0);
        chk("bubble_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("bubble_hold_reg", {27'd0, wb_write_reg}, 32'd8);
        chk("bubble_hold_data", wb_write_data, 32'h1234_5678);

        // Back-to-back loads with data present, plus link and src=11
        load(5'd9, 2'b10, 1'b0, 2'b11, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'hFFFF_FF80, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd9, 2'b10, 1'b0, 2'b01, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'h0000_007F, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd9, 2'b10, 1'b1, 2'b11, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'h0000_0080, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd9, 2'b01, 1'b0, 2'b10, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'hFFFF_80FF, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd9, 2'b01, 1'b0, 2'b00, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'h0000_7F01, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd9, 2'b00, 1'b0, 2'b00, 32'h80FF_7F01, 1'b1); push(1'b1, 5'd9, 32'h80FF_7F01, 1'b0, 1'b1);
        @(negedge clk);
        alu(5'd31, 2'b10, 32'h0040_0010); push(1'b1, 5'd31, 32'h0040_0010, 1'b0, 1'b1);
        @(negedge clk);
        alu(5'd7, 2'b11, 32'h0BAD_CAFE); push(1'b1, 5'd7, 32'h0BAD_CAFE, 1'b0, 1'b1);
        @(negedge clk); idle();

        // Halfword unsigned with late data; ex_* perturbed while waiting
        @(negedge clk);
        load(5'd10, 2'b01, 1'b1, 2'b10, 32'h0000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wait_stall", {31'd0, stall_out}, 32'd1);
            chk("wait_bubble", {31'd0, wb_valid}, 32'd0);
            ex_addr_low = 2'b00; ex_write_reg = 5'd3; ex_load_size = 2'b00;
            mem_rvalid = (k == 3);
            mem_rdata  = (k == 3) ? 32'hBEEF_0000 : 32'h5555_5555;
            if (k == 3) push(1'b1, 5'd10, 32'h0000_BEEF, 1'b0, 1'b1);
        end
        @(negedge clk);
        chk("late_stall_drop", {31'd0, stall_out}, 32'd0);
        chk("late_valid", {31'd0, wb_valid}, 32'd1);
        idle();

        // Misaligned word and halfword, then one misaligned with late data
        load(5'd11, 2'b00, 1'b0, 2'b10, 32'hAAAA_BBBB, 1'b1); push(1'b0, 5'd11, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        load(5'd11, 2'b01, 1'b0, 2'b01, 32'hAAAA_BBBB, 1'b1); push(1'b0, 5'd11, 32'd0, 1'b1, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        chk("misalign_one_cycle", {31'd0, wb_misalign}, 32'd0);
        load(5'd14, 2'b00, 1'b0, 2'b01, 32'h0, 1'b0);
        @(negedge clk);
        chk("mis_wait_stall", {31'd0, stall_out}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF; push(1'b0, 5'd14, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mis_wait_release", {31'd0, stall_out}, 32'd0);
        idle();

        // Flush together with rvalid during WAIT: no writeback
        load(5'd12, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0);
        @(negedge clk);
        chk("flush_pre_stall", {31'd0, stall_out}, 32'd1);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("flush_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_stall", {31'd0, stall_out}, 32'd0);
        alu(5'd13, 2'b00, 32'hA5A5_0001); push(1'b1, 5'd13, 32'hA5A5_0001, 1'b0, 1'b1);
        @(negedge clk);
        idle(); mem_rvalid = 1'b1;      // stray rvalid in IDLE is ignored
        @(negedge clk);
        chk("stray_rvalid", {31'd0, wb_valid}, 32'd0);
        alu(5'd15, 2'b00, 32'h7777_7777); flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_valid", {31'd0, wb_valid}, 32'd0);
        idle();

        // Link to r0: valid but never written
        alu(5'd0, 2'b10, 32'h0040_0008); push(1'b0, 5'd0, 32'h0040_0008, 1'b0, 1'b1);
        @(negedge clk);
        load(5'd16, 2'b00, 1'b0, 2'b00, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre_reset_stall", {31'd0, stall_out}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_stall", {31'd0, stall_out}, 32'd0);
        chk("async_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("async_mis", {31'd0, wb_misalign}, 32'd0);
        chk("async_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("async_data", wb_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        alu(5'd17, 2'b00, 32'hCAFE_F00D); push(1'b1, 5'd17, 32'hCAFE_F00D, 1'b0, 1'b1);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the pipelined MIPS core.
- Registers the instruction leaving the memory stage and selects the writeback source: ALU result, load data or link address.
- Aligns and extends sub-word load data, and waits for slow memory read data.
- Drives the register-file write port (RegWrite / Write_register / Write_data) one cycle after capture.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  an instruction is presented by the MEM stage.
- ex_reg_write  input  1  the instruction writes a register.
- ex_write_reg  input  5  destination register.
- ex_mem_to_reg  input  2  writeback source: 00 ALU, 01 load, 10 link (PC+4), 11 treated as ALU.
- ex_load_size  input  2  load size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- ex_load_unsigned  input  1  zero-extend (1) or sign-extend (0) sub-word loads.
- ex_addr_low  input  2  bits [1:0] of the load address.
- ex_alu_result  input  32  ALU result.
- ex_pc_plus4  input  32  link address.
- mem_rdata  input  32  data-memory read word.
- mem_rvalid  input  1  mem_rdata is valid this cycle.
- flush  input  1  synchronous kill of the in-flight instruction.
- stall_out  output  1  upstream must hold all ex_* stable.
- wb_valid  output  1  writeback slot holds a real instruction.
- wb_reg_write  output  1  register-file write enable.
- wb_write_reg  output  5  register-file write address.
- wb_write_data  output  32  register-file write data.
- wb_misalign  output  1  one-cycle misaligned-load flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; stall_out, wb_valid, wb_reg_write, wb_misalign = 0; wb_write_reg = 0; wb_write_data = 0.
- States:
  - IDLE: accepts ex_*.
  - WAIT: load captured, read data outstanding. ex_* ignored.
- stall_out is registered: high exactly while state==WAIT, including the cycle in which rvalid is consumed.
- Capture in IDLE with ex_valid=1 and flush=0:
  - Non-load, or load with mem_rvalid=1: result appears on wb_* at the next edge (latency 1). wb_valid=1. State stays IDLE.
  - Load with mem_rvalid=0: latch the control fields and ex_addr_low, go to WAIT. wb_* is a bubble next cycle.
- ex_valid=0 in IDLE: bubble. Bubble means wb_valid=0, wb_reg_write=0, wb_misalign=0; wb_write_reg and wb_write_data hold their previous values.
- WAIT:
  - Each cycle with mem_rvalid=0 emits a bubble.
  - On mem_rvalid=1: next edge outputs the load result with wb_valid=1 and goes to IDLE. stall_out drops on that same edge.
  - Upstream therefore presents its next instruction in the cycle after the result.
- Writeback data:
  - ALU source: ex_alu_result. Link source: ex_pc_plus4.
  - Load, word: mem_rdata.
  - Load, halfword, little-endian: addr_low[1]=0 selects [15:0], 1 selects [31:16].
  - Load, byte: addr_low selects byte 0..3 at [8k+7:8k].
  - Sub-word loads are sign- or zero-extended to 32 bits per ex_load_unsigned.
- Misalignment: word load with addr_low≠00, or halfword load with addr_low[0]=1.
  - Result: wb_misalign=1, wb_valid=1, wb_reg_write=0.
  - A misaligned load still waits for mem_rvalid if it is not present.
- wb_reg_write = valid & ex_reg_write & (write_reg≠0) & ~misalign. Writes to register 0 are never enabled.
- Flush (highest priority): next edge produces a bubble and state=IDLE. Any pending WAIT is abandoned. A later mem_rvalid is ignored in IDLE unless it coincides with a new load capture.
- Flush and mem_rvalid in the same WAIT cycle: flush wins, no writeback.
- Reset mid-WAIT: immediate return to IDLE, all outputs cleared.

Test Plan:
1. ALU op: ex_valid=1, reg_write=1, write_reg=8, mem_to_reg=00, alu=0x1234_5678 -> next cycle wb_valid=1, wb_reg_write=1, wb_write_reg=8, wb_write_data=0x1234_5678.
2. Byte load, signed: rdata=0x80FF_7F01, size=10, addr_low=11, unsigned=0, mem_rvalid=1 -> wb_write_data=0xFFFF_FF80. Repeat with addr_low=01 -> 0x0000_007F.
3. Halfword load, unsigned, late data: addr_low=10, mem_rvalid low 3 cycles then high with rdata=0xBEEF_0000:
   - stall_out=1 for 4 cycles; 3 bubble cycles plus the rvalid cycle.
   - Then wb_write_data=0x0000_BEEF, wb_valid=1, stall_out=0 on the same edge.
4. Misaligned word load: addr_low=10 -> wb_misalign=1 for one cycle, wb_reg_write=0. Halfword with addr_low=01 -> same result.
5. Flush during WAIT: load pending, assert flush together with mem_rvalid=1 -> no writeback, state IDLE, stall_out=0 next cycle. A following ALU op is accepted normally.
6. Register 0 and reset:
   - Link op to write_reg=0, pc_plus4=0x0040_0008 -> wb_valid=1, wb_reg_write=0.
   - Assert reset mid-WAIT -> all outputs 0 immediately, with no clock edge.
